acc_cpu_core: RTL and testbench

Parametrised successor to the single-cycle accumulator datapath. It integrates the accumulator datapath with its own multi-cycle control FSM, so no external ld_ac/ac_src/pc_src strobes are needed. It adds Z/C flags, conditional branches and HLT, and a req/ready handshake to a variable-latency data memory. It sits between a combinational-read instruction memory and the data memory / LED debug logic.

---
 rtl/acc_cpu_pkg.sv | 29 ++
 rtl/acc_cpu_core_if.sv | 15 +
 rtl/acc_alu.sv | 38 +++
 rtl/acc_cpu_core.sv | 135 +++++++++++++
 tb/tb_acc_cpu_core.sv | 336 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/acc_cpu_pkg.sv
// Shared opcodes, FSM state encoding and instruction-width helper for the accumulator core.
package acc_cpu_pkg;

  localparam int unsigned OpcodeW = 4;

  localparam logic [3:0] OpNop = 4'h0;
  localparam logic [3:0] OpLda = 4'h1;
  localparam logic [3:0] OpSta = 4'h2;
  localparam logic [3:0] OpAdd = 4'h3;
  localparam logic [3:0] OpSub = 4'h4;
  localparam logic [3:0] OpAnd = 4'h5;
  localparam logic [3:0] OpOr  = 4'h6;
  localparam logic [3:0] OpXor = 4'h7;
  localparam logic [3:0] OpJmp = 4'h8;
  localparam logic [3:0] OpJz  = 4'h9;
  localparam logic [3:0] OpJc  = 4'hA;
  localparam logic [3:0] OpNot = 4'hB;
  localparam logic [3:0] OpHlt = 4'hF;

  localparam logic [1:0] StFetch = 2'd0;
  localparam logic [1:0] StExec  = 2'd1;
  localparam logic [1:0] StMem   = 2'd2;
  localparam logic [1:0] StHalt  = 2'd3;

  function automatic int unsigned instrWidth(input int unsigned addrW);
    return OpcodeW + addrW;
  endfunction

endpackage

// File: rtl/acc_cpu_core_if.sv
// Data-memory request/ready bus between the core (master) and memory (slave).
interface acc_cpu_core_if #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 4
);
  logic              req;
  logic              we;
  logic              ready;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata;

  modport master (output req, we, addr, wdata, input ready, rdata);
  modport slave  (input req, we, addr, wdata, output ready, rdata);
endinterface

// File: rtl/acc_alu.sv
// Combinational accumulator ALU: load passthrough, add/sub with carry, logic ops and NOT.
module acc_alu
  import acc_cpu_pkg::*;
#(
  parameter int unsigned DATA_W = 8
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [3:0]        op,
  output logic [DATA_W-1:0] y,
  output logic              c
);

  logic [DATA_W:0] sum;
  logic [DATA_W:0] diff;

  assign sum  = {1'b0, a} + {1'b0, b};
  assign diff = {1'b0, a} - {1'b0, b};

  always_comb begin
    y = b;
    c = 1'b0;
    case (op)
      OpAdd: {c, y} = sum;
      OpSub: begin
        y = diff[DATA_W-1:0];
        // Carry means "no borrow", i.e. a >= b.
        c = ~diff[DATA_W];
      end
      OpAnd:   y = a & b;
      OpOr:    y = a | b;
      OpXor:   y = a ^ b;
      OpNot:   y = ~a;
      default: y = b;
    endcase
  end

endmodule

// File: rtl/acc_cpu_core.sv
// Multi-cycle accumulator CPU: FETCH/EXEC/MEM/HALT control, Z/C flags, branches,
// and a req/ready handshake to variable-latency data memory.
module acc_cpu_core
  import acc_cpu_pkg::*;
#(
  parameter int unsigned      DATA_W   = 8,
  parameter int unsigned      ADDR_W   = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          run,
  output logic [ADDR_W-1:0]             im_addr,
  input  logic [instrWidth(ADDR_W)-1:0] im_data,
  acc_cpu_core_if.master                dm,
  output logic [DATA_W-1:0]             ac_out,
  output logic [ADDR_W-1:0]             pc_out,
  output logic                          flag_z,
  output logic                          flag_c,
  output logic                          halted,
  output logic [1:0]                    state_out
);

  localparam int unsigned InstrW = instrWidth(ADDR_W);

  logic [1:0]        stateQ, stateD;
  logic [ADDR_W-1:0] pcQ, pcD;
  logic [DATA_W-1:0] acQ, acD;
  logic [InstrW-1:0] irQ, irD;
  logic              zQ, zD, cQ, cD, haltedQ, haltedD;

  logic [3:0]        op;
  logic [ADDR_W-1:0] operand;
  logic              isMem;
  logic              done;
  logic [DATA_W-1:0] aluY;
  logic              aluC;

  assign op      = irQ[InstrW-1 -: OpcodeW];
  assign operand = irQ[ADDR_W-1:0];
  assign isMem   = (op >= OpLda) && (op <= OpXor);

  assign dm.req   = ((stateQ == StExec) && isMem) || (stateQ == StMem);
  assign dm.we    = dm.req && (op == OpSta);
  assign dm.addr  = operand;
  assign dm.wdata = acQ;
  assign done     = dm.req && dm.ready;

  acc_alu #(
    .DATA_W(DATA_W)
  ) u_alu (
    .a (acQ),
    .b (dm.rdata),
    .op(op),
    .y (aluY),
    .c (aluC)
  );

  always_comb begin
    stateD  = stateQ;
    pcD     = pcQ;
    acD     = acQ;
    irD     = irQ;
    zD      = zQ;
    cD      = cQ;
    haltedD = haltedQ;
    case (stateQ)
      StFetch: begin
        if (run) begin
          irD    = im_data;
          pcD    = pcQ + 1'b1;
          stateD = StExec;
        end
      end
      StExec, StMem: begin
        if ((stateQ == StExec) && !isMem) begin
          stateD = StFetch;
          case (op)
            OpJmp: pcD = operand;
            OpJz:  if (zQ) pcD = operand;
            OpJc:  if (cQ) pcD = operand;
            OpNot: begin
              acD = aluY;
              zD  = (aluY == '0);
            end
            OpHlt: begin
              stateD  = StHalt;
              haltedD = 1'b1;
            end
            default: ;
          endcase
        end else if (done) begin
          stateD = StFetch;
          if (op != OpSta) begin
            acD = aluY;
            zD  = (aluY == '0);
            if ((op == OpAdd) || (op == OpSub)) cD = aluC;
          end
        end else begin
          stateD = StMem;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      stateQ  <= StFetch;
      pcQ     <= RESET_PC;
      acQ     <= '0;
      irQ     <= '0;
      zQ      <= 1'b0;
      cQ      <= 1'b0;
      haltedQ <= 1'b0;
    end else begin
      stateQ  <= stateD;
      pcQ     <= pcD;
      acQ     <= acD;
      irQ     <= irD;
      zQ      <= zD;
      cQ      <= cD;
      haltedQ <= haltedD;
    end
  end

  assign im_addr   = pcQ;
  assign pc_out    = pcQ;
  assign ac_out    = acQ;
  assign flag_z    = zQ;
  assign flag_c    = cQ;
  assign halted    = haltedQ;
  assign state_out = stateQ;

endmodule

// File: tb/tb_acc_cpu_core.sv
// Bench for acc_cpu_core: directed programs plus random programs checked against an
// instruction-level reference model; a second instance covers DATA_W=16, ADDR_W=6.
module tb_acc_cpu_core;
  import acc_cpu_pkg::*;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic reset, run8, run16, ready8;
  int checks   = 0;
  int failures = 0;

  // 8-bit instance
  logic [3:0] imAddr8, pc8;
  logic [7:0] imData8, ac8;
  logic       z8, c8, halted8;
  logic [1:0] state8;
  logic [7:0] imem [16];
  logic [7:0] dmem [16];

  acc_cpu_core_if #(.DATA_W(8), .ADDR_W(4)) bus8 ();
  assign imData8    = imem[imAddr8];
  assign bus8.ready = ready8;
  assign bus8.rdata = dmem[bus8.addr];
  always @(posedge clock) begin
    if (!reset && bus8.req && bus8.ready && bus8.we) dmem[bus8.addr] = bus8.wdata;
  end

  acc_cpu_core #(.DATA_W(8), .ADDR_W(4), .RESET_PC(4'd0)) dut8 (
    .clock    (clock),
    .reset    (reset),
    .run      (run8),
    .im_addr  (imAddr8),
    .im_data  (imData8),
    .dm       (bus8),
    .ac_out   (ac8),
    .pc_out   (pc8),
    .flag_z   (z8),
    .flag_c   (c8),
    .halted   (halted8),
    .state_out(state8)
  );

  // 16-bit instance, data memory always ready
  logic [5:0]  imAddr16, pc16;
  logic [9:0]  imData16;
  logic [15:0] ac16;
  logic        z16, c16, halted16;
  logic [1:0]  state16;
  logic [9:0]  imem16 [64];
  logic [15:0] dmem16 [64];

  acc_cpu_core_if #(.DATA_W(16), .ADDR_W(6)) bus16 ();
  assign imData16    = imem16[imAddr16];
  assign bus16.ready = 1'b1;
  assign bus16.rdata = dmem16[bus16.addr];

  acc_cpu_core #(.DATA_W(16), .ADDR_W(6), .RESET_PC(6'd2)) dut16 (
    .clock    (clock),
    .reset    (reset),
    .run      (run16),
    .im_addr  (imAddr16),
    .im_data  (imData16),
    .dm       (bus16),
    .ac_out   (ac16),
    .pc_out   (pc16),
    .flag_z   (z16),
    .flag_c   (c16),
    .halted   (halted16),
    .state_out(state16)
  );

  // Instruction-level reference model of the 8-bit core
  logic [3:0] mpc;
  logic [7:0] mac;
  logic       mz, mc, mhalt;
  logic [7:0] mmem [16];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic doReset();
    reset  = 1'b1;
    run8   = 1'b0;
    run16  = 1'b0;
    ready8 = 1'b0;
    tick();
    reset = 1'b0;
    mpc   = 4'd0;
    mac   = 8'd0;
    mz    = 1'b0;
    mc    = 1'b0;
    mhalt = 1'b0;
  endtask

  task automatic loadModelMem();
    for (int i = 0; i < 16; i++) mmem[i] = dmem[i];
  endtask

  task automatic modelStep();
    logic [7:0] instr;
    logic [3:0] op, a;
    int         opnd, res;
    instr = imem[mpc];
    op    = instr[7:4];
    a     = instr[3:0];
    opnd  = int'(mmem[a]);
    mpc   = mpc + 4'd1;
    res   = int'(mac);
    case (op)
      4'h1: res = opnd;
      4'h2: mmem[a] = mac;
      4'h3: begin res = int'(mac) + opnd; mc = (res > 255); end
      4'h4: begin mc = (int'(mac) >= opnd); res = int'(mac) - opnd; end
      4'h5: res = int'(mac & mmem[a]);
      4'h6: res = int'(mac | mmem[a]);
      4'h7: res = int'(mac ^ mmem[a]);
      4'h8: mpc = a;
      4'h9: if (mz) mpc = a;
      4'hA: if (mc) mpc = a;
      4'hB: res = int'(~mac);
      4'hF: mhalt = 1'b1;
      default: ;
    endcase
    if ((op >= 4'h1 && op <= 4'h7 && op != 4'h2) || op == 4'hB) begin
      mac = res[7:0];
      mz  = (mac == 8'd0);
    end
  endtask

  // One instruction, open-loop timing: FETCH, EXEC, then 'stalls' MEM cycles for memory ops.
  task automatic runInstr(input int stalls);
    logic [7:0] instr, acBefore;
    logic [3:0] op, a;
    logic       memOp;
    instr    = imem[mpc];
    op       = instr[7:4];
    a        = instr[3:0];
    memOp    = (op >= 4'h1) && (op <= 4'h7);
    acBefore = mac;
    check("fetch_state", 32'(state8), 32'd0);
    run8   = 1'b1;
    ready8 = 1'b0;
    tick();
    run8 = 1'b0;
    check("exec_state", 32'(state8), 32'd1);
    check("exec_req", 32'(bus8.req), 32'(memOp));
    if (memOp) begin
      for (int k = 0; k <= stalls; k++) begin
        if (k > 0) begin
          check("stall_req", 32'(bus8.req), 32'd1);
          check("stall_state", 32'(state8), 32'd2);
        end
        check("dm_addr", 32'(bus8.addr), 32'(a));
        check("dm_we", 32'(bus8.we), 32'(op == 4'h2));
        check("ac_hold", 32'(ac8), 32'(acBefore));
        if (op == 4'h2) check("dm_wdata", 32'(bus8.wdata), 32'(acBefore));
        ready8 = (k == stalls);
        tick();
      end
      ready8 = 1'b0;
    end else begin
      tick();
    end
    modelStep();
    check("state", 32'(state8), mhalt ? 32'd3 : 32'd0);
    check("pc", 32'(pc8), 32'(mpc));
    check("ac", 32'(ac8), 32'(mac));
    check("z", 32'(z8), 32'(mz));
    check("c", 32'(c8), 32'(mc));
    check("halted", 32'(halted8), 32'(mhalt));
    if (op == 4'h2) check("sta_mem", 32'(dmem[a]), 32'(mmem[a]));
  endtask

  task automatic freeze(input int n);
    run8 = 1'b0;
    for (int i = 0; i < n; i++) tick();
    check("frz_state", 32'(state8), 32'd0);
    check("frz_pc", 32'(pc8), 32'(mpc));
    check("frz_ac", 32'(ac8), 32'(mac));
  endtask

  task automatic clearMem();
    for (int i = 0; i < 16; i++) begin
      imem[i] = 8'h00;
      dmem[i] = 8'h00;
    end
  endtask

  initial begin
    reset  = 1'b1;
    run8   = 1'b0;
    run16  = 1'b0;
    ready8 = 1'b0;

    // LDA 3; ADD 4; STA 5; HLT with memory always ready
    clearMem();
    imem[0] = 8'h13; imem[1] = 8'h34; imem[2] = 8'h25; imem[3] = 8'hF0;
    dmem[3] = 8'hF0; dmem[4] = 8'h20;
    doReset();
    check("rst_pc", 32'(pc8), 32'd0);
    check("rst_ac", 32'(ac8), 32'd0);
    check("rst_state", 32'(state8), 32'd0);
    check("rst_req", 32'(bus8.req), 32'd0);
    check("rst_we", 32'(bus8.we), 32'd0);
    check("rst_flags", {30'd0, z8, c8}, 32'd0);
    check("rst_halted", 32'(halted8), 32'd0);
    run8   = 1'b1;
    ready8 = 1'b1;
    for (int i = 0; i < 7; i++) tick();
    check("prog_not_yet_halted", 32'(halted8), 32'd0);
    tick();
    check("prog_halted", 32'(halted8), 32'd1);
    check("prog_state", 32'(state8), 32'd3);
    check("prog_pc", 32'(pc8), 32'd4);
    check("prog_ac", 32'(ac8), 32'h10);
    check("prog_c", 32'(c8), 32'd1);
    check("prog_z", 32'(z8), 32'd0);
    check("prog_mem5", 32'(dmem[5]), 32'h10);
    for (int i = 0; i < 3; i++) tick();
    check("halt_pc", 32'(pc8), 32'd4);
    check("halt_req", 32'(bus8.req), 32'd0);
    check("halt_state", 32'(state8), 32'd3);

    // Reset while an ADD is stalled in MEM
    clearMem();
    imem[0] = 8'h13; imem[1] = 8'h34; imem[2] = 8'h34;
    dmem[3] = 8'hF0; dmem[4] = 8'h20;
    doReset();
    loadModelMem();
    runInstr(0);
    runInstr(1);
    check("pre_rst_c", 32'(c8), 32'd1);
    run8 = 1'b1;
    tick();
    run8 = 1'b0;
    tick();
    check("mid_mem_req", 32'(bus8.req), 32'd1);
    check("mid_mem_state", 32'(state8), 32'd2);
    reset  = 1'b1;
    ready8 = 1'b1;
    tick();
    reset = 1'b0;
    check("rstmem_req", 32'(bus8.req), 32'd0);
    check("rstmem_state", 32'(state8), 32'd0);
    check("rstmem_pc", 32'(pc8), 32'd0);
    check("rstmem_ac", 32'(ac8), 32'd0);
    check("rstmem_flags", {30'd0, z8, c8}, 32'd0);
    tick();
    check("rstmem_ac_after", 32'(ac8), 32'd0);
    check("rstmem_state_after", 32'(state8), 32'd0);
    ready8 = 1'b0;

    // SUB to zero and JZ taken; SUB with borrow and JZ not taken; stalled LDA; PC wrap
    clearMem();
    imem[0]  = 8'h16; imem[1]  = 8'h47; imem[2]  = 8'h9A;
    imem[10] = 8'h18; imem[11] = 8'h47; imem[12] = 8'h90;
    imem[13] = 8'h8F; imem[15] = 8'h00;
    dmem[6] = 8'h05; dmem[7] = 8'h05; dmem[8] = 8'h04;
    doReset();
    loadModelMem();
    runInstr(0);
    runInstr(1);
    check("sub_eq_ac", 32'(ac8), 32'd0);
    check("sub_eq_zc", {30'd0, z8, c8}, 32'd3);
    runInstr(0);
    check("jz_taken_pc", 32'(pc8), 32'hA);
    runInstr(3);
    check("lda_stall_ac", 32'(ac8), 32'h04);
    runInstr(0);
    check("sub_borrow_ac", 32'(ac8), 32'hFF);
    check("sub_borrow_zc", {30'd0, z8, c8}, 32'd0);
    runInstr(0);
    check("jz_not_taken_pc", 32'(pc8), 32'hD);
    runInstr(0);
    runInstr(0);
    check("pc_wrap", 32'(pc8), 32'd0);
    freeze(4);

    // Random programs (no HLT) with random stalls and run gaps
    for (int iter = 0; iter < 4; iter++) begin
      for (int i = 0; i < 16; i++) begin
        imem[i] = {4'($urandom_range(0, 14)), 4'($urandom_range(0, 15))};
        dmem[i] = 8'($urandom_range(0, 255));
      end
      doReset();
      loadModelMem();
      for (int n = 0; n < 40; n++) begin
        runInstr(int'($urandom_range(0, 3)));
        if ($urandom_range(0, 7) == 0) freeze(int'($urandom_range(1, 4)));
      end
    end

    // 16-bit data, 6-bit address, RESET_PC=2: LDA 1; ADD 2; JC 0x3F; NOP at 0x3F
    for (int i = 0; i < 64; i++) begin
      imem16[i] = 10'd0;
      dmem16[i] = 16'd0;
    end
    imem16[2] = {4'h1, 6'd1};
    imem16[3] = {4'h3, 6'd2};
    imem16[4] = {4'hA, 6'h3F};
    dmem16[1] = 16'hFFFF;
    dmem16[2] = 16'h0001;
    doReset();
    check("w16_rst_pc", 32'(pc16), 32'd2);
    run16 = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    check("w16_add_ac", 32'(ac16), 32'd0);
    check("w16_add_z", 32'(z16), 32'd1);
    check("w16_add_c", 32'(c16), 32'd1);
    check("w16_add_pc", 32'(pc16), 32'd4);
    tick();
    tick();
    check("w16_jc_pc", 32'(pc16), 32'h3F);
    tick();
    tick();
    check("w16_wrap_pc", 32'(pc16), 32'd0);
    check("w16_state", 32'(state16), 32'd0);
    run16 = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
